// File: rtl/ldpc_3gpp_dec_obuffer_rdctrl.sv
`default_nettype none
// ============================================================================
// Module   : ldpc_3gpp_dec_obuffer_rdctrl
// Purpose  : Read-side sequencer of the LDPC decoder 2D output buffer. Waits
//            for a filled bank, sweeps read addresses 0..len, absorbs the
//            2-tick RAM read latency through a token pipe and a 4-entry
//            first-word-fall-through FIFO, and presents the words as a
//            valid/ready stream with sop/eop markers and the block tag.
//            The bank is released once its last word has left the RAM pipe.
// Ports    : iclk/ireset/iclkena - clock, async active-low reset, clock enable
//            ilen_m1              - words per block minus 1 (sampled at start)
//            ibuf_empty/rdat/rtag - buffer status, read data, bank tag
//            obuf_rempty          - one-tick bank release pulse
//            obuf_raddr           - buffer read address
//            ordy/oval/osop/oeop/odat/otag - output stream
//            obusy                - block in progress (start to release)
// Revision : 1.0 - initial release
// ============================================================================
module ldpc_3gpp_dec_obuffer_rdctrl #(
   parameter int pRADDR_W = 8,
   parameter int pRDAT_W  = 8,
   parameter int pDAT_NUM = 8,
   parameter int pTAG_W   = 4
) (
   input  logic                        iclk,
   input  logic                        ireset,
   input  logic                        iclkena,
   input  logic [pRADDR_W-1:0]         ilen_m1,
   input  logic                        ibuf_empty,
   input  logic [pRDAT_W*pDAT_NUM-1:0] ibuf_rdat,
   input  logic [pTAG_W-1:0]           ibuf_rtag,
   output logic                        obuf_rempty,
   output logic [pRADDR_W-1:0]         obuf_raddr,
   input  logic                        ordy,
   output logic                        oval,
   output logic                        osop,
   output logic                        oeop,
   output logic [pRDAT_W*pDAT_NUM-1:0] odat,
   output logic [pTAG_W-1:0]           otag,
   output logic                        obusy
);

   localparam int c_DAT_W = pRDAT_W * pDAT_NUM;

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_READ  = 2'd1;
   localparam logic [1:0] c_FLUSH = 2'd2;
   localparam logic [1:0] c_GAP   = 2'd3;

   logic [1:0]          state_q, state_d;
   logic [pRADDR_W-1:0] len_q, len_d;
   logic [pRADDR_W-1:0] raddr_q, raddr_d;
   logic                rempty_q, rempty_d;

   // token pipe aligned with the RAM read latency
   logic p1_val_q, p1_sop_q, p1_eop_q;
   logic p2_val_q, p2_sop_q, p2_eop_q;

   // output FIFO
   logic [c_DAT_W-1:0] fifo_dat_q [4];
   logic [3:0]         fifo_sop_q, fifo_eop_q;
   logic [1:0]         fifo_wr_q, fifo_rd_q;
   logic [2:0]         fifo_used_q;

   // tags of blocks whose first word has not yet left the FIFO
   logic [pTAG_W-1:0] tq_q [2];
   logic              tq_wr_q, tq_rd_q;
   logic [1:0]        tq_used_q;
   logic [pTAG_W-1:0] otag_q;

   logic [2:0] w_inflight;
   logic       w_issue, w_start, w_push, w_pop, w_pop_sop, w_head_sop;

   // Words in the FIFO plus words still inside the RAM pipe must never
   // exceed the FIFO depth, so a stalled sink can never cause an overflow.
   assign w_inflight = fifo_used_q + {2'b00, p1_val_q} + {2'b00, p2_val_q};
   assign w_issue    = (state_q == c_READ) && (w_inflight < 3'd4);
   // A third pending tag cannot be held; starting is deferred until the
   // first word of an older block has been taken by the sink.
   assign w_start    = (state_q == c_IDLE) && !ibuf_empty && (tq_used_q != 2'd2);
   assign w_push     = p2_val_q;
   assign w_head_sop = fifo_sop_q[fifo_rd_q];
   assign w_pop      = oval && ordy;
   assign w_pop_sop  = w_pop && w_head_sop;

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      raddr_d  = raddr_q;
      rempty_d = 1'b0;
      case (state_q)
         c_IDLE: begin
            if (w_start) begin
               len_d   = ilen_m1;
               raddr_d = '0;
               state_d = c_READ;
            end
         end
         c_READ: begin
            if (w_issue) begin
               // address holds at len once the last word is issued
               if (raddr_q == len_q) state_d = c_FLUSH;
               else                  raddr_d = raddr_q + 1'b1;
            end
         end
         c_FLUSH: begin
            if (p2_val_q && p2_eop_q) begin
               rempty_d = 1'b1;
               state_d  = c_GAP;
            end
         end
         // the buffer's empty flag is stale in this cycle
         c_GAP:   state_d = c_IDLE;
         default: state_d = c_IDLE;
      endcase
   end

   always_ff @(posedge iclk or negedge ireset) begin
      if (!ireset) begin
         state_q  <= c_IDLE;
         len_q    <= '0;
         raddr_q  <= '0;
         rempty_q <= 1'b0;
      end else if (iclkena) begin
         state_q  <= state_d;
         len_q    <= len_d;
         raddr_q  <= raddr_d;
         rempty_q <= rempty_d;
      end
   end

   always_ff @(posedge iclk or negedge ireset) begin
      if (!ireset) begin
         p1_val_q    <= 1'b0;
         p1_sop_q    <= 1'b0;
         p1_eop_q    <= 1'b0;
         p2_val_q    <= 1'b0;
         p2_sop_q    <= 1'b0;
         p2_eop_q    <= 1'b0;
         for (int i = 0; i < 4; i++) fifo_dat_q[i] <= '0;
         fifo_sop_q  <= '0;
         fifo_eop_q  <= '0;
         fifo_wr_q   <= '0;
         fifo_rd_q   <= '0;
         fifo_used_q <= '0;
         tq_q[0]     <= '0;
         tq_q[1]     <= '0;
         tq_wr_q     <= 1'b0;
         tq_rd_q     <= 1'b0;
         tq_used_q   <= '0;
         otag_q      <= '0;
      end else if (iclkena) begin
         p1_val_q <= w_issue;
         p1_sop_q <= w_issue && (raddr_q == '0);
         p1_eop_q <= w_issue && (raddr_q == len_q);
         p2_val_q <= p1_val_q;
         p2_sop_q <= p1_sop_q;
         p2_eop_q <= p1_eop_q;

         if (w_push) begin
            fifo_dat_q[fifo_wr_q] <= ibuf_rdat;
            fifo_sop_q[fifo_wr_q] <= p2_sop_q;
            fifo_eop_q[fifo_wr_q] <= p2_eop_q;
            fifo_wr_q             <= fifo_wr_q + 1'b1;
         end
         if (w_pop) fifo_rd_q <= fifo_rd_q + 1'b1;
         fifo_used_q <= fifo_used_q + {2'b00, w_push} - {2'b00, w_pop};

         if (w_start) begin
            tq_q[tq_wr_q] <= ibuf_rtag;
            tq_wr_q       <= ~tq_wr_q;
         end
         if (w_pop_sop) begin
            otag_q  <= tq_q[tq_rd_q];
            tq_rd_q <= ~tq_rd_q;
         end
         tq_used_q <= tq_used_q + {1'b0, w_start} - {1'b0, w_pop_sop};
      end
   end

   assign oval        = (fifo_used_q != 3'd0);
   assign osop        = oval && w_head_sop;
   assign oeop        = oval && fifo_eop_q[fifo_rd_q];
   assign odat        = fifo_dat_q[fifo_rd_q];
   // the tag switches exactly when a block's first word reaches the head
   assign otag        = (osop && (tq_used_q != 2'd0)) ? tq_q[tq_rd_q] : otag_q;
   assign obuf_raddr  = raddr_q;
   assign obuf_rempty = rempty_q && iclkena;
   assign obusy       = (state_q == c_READ) || (state_q == c_FLUSH);

endmodule
`default_nettype wire

// File: tb/tb_ldpc_3gpp_dec_obuffer_rdctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ldpc_3gpp_dec_obuffer_rdctrl
// Purpose  : Bench for the output-buffer read sequencer. A bank queue plays
//            the buffer (empty flag, tag, length, 2-tick RAM with per-bank
//            data pattern); the expected word stream is built per bank from
//            its length and tag and compared with every accepted word.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ldpc_3gpp_dec_obuffer_rdctrl;

   localparam int AW = 8;
   localparam int DW = 8;
   localparam int DN = 8;
   localparam int TW = 4;
   localparam int WW = DW * DN;

   typedef struct {
      int            id;
      logic [AW-1:0] len;
      logic [TW-1:0] tag;
   } bank_t;

   typedef struct {
      logic [WW-1:0] dat;
      logic          sop;
      logic          eop;
      logic [TW-1:0] tag;
   } word_t;

   logic          iclk = 1'b0;
   logic          ireset = 1'b0;
   logic          iclkena = 1'b1;
   logic [AW-1:0] ilen_m1 = '0;
   logic          ibuf_empty = 1'b1;
   logic [WW-1:0] ibuf_rdat;
   logic [TW-1:0] ibuf_rtag = '0;
   logic          obuf_rempty;
   logic [AW-1:0] obuf_raddr;
   logic          ordy = 1'b1;
   logic          oval, osop, oeop;
   logic [WW-1:0] odat;
   logic [TW-1:0] otag;
   logic          obusy;

   bank_t pending[$];
   word_t exp_q[$];
   int    cur_id = -1;
   int    bank_ctr = 0;
   int    rel_cnt = 0;
   int    exp_rel = 0;
   int    n_pass = 0;
   int    n_total = 0;
   int    n_fail = 0;
   logic [WW-1:0] ram_s1 = '0;
   logic [WW-1:0] ram_s2 = '0;

   ldpc_3gpp_dec_obuffer_rdctrl #(
      .pRADDR_W(AW), .pRDAT_W(DW), .pDAT_NUM(DN), .pTAG_W(TW)
   ) dut (
      .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .ilen_m1(ilen_m1),
      .ibuf_empty(ibuf_empty), .ibuf_rdat(ibuf_rdat), .ibuf_rtag(ibuf_rtag),
      .obuf_rempty(obuf_rempty), .obuf_raddr(obuf_raddr), .ordy(ordy),
      .oval(oval), .osop(osop), .oeop(oeop), .odat(odat), .otag(otag),
      .obusy(obusy)
   );

   always #5 iclk = ~iclk;

   function automatic logic [WW-1:0] gen(input int id, input logic [AW-1:0] a);
      logic [15:0] i16;
      i16 = id[15:0];
      return {i16, 16'hC0DE, a, a ^ 8'h5A, i16[7:0] ^ a, 8'h11};
   endfunction

   // buffer RAM: 2-tick read latency, content belongs to the bank under read
   always @(posedge iclk) begin
      if (iclkena) begin
         ram_s1 <= gen(cur_id, obuf_raddr);
         ram_s2 <= ram_s1;
      end
   end
   assign ibuf_rdat = ram_s2;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic update_buf();
      ibuf_empty = (pending.size() == 0);
      if (pending.size() != 0) begin
         ibuf_rtag = pending[0].tag;
         ilen_m1   = pending[0].len;
         cur_id    = pending[0].id;
      end
   endtask

   task automatic push_block(input int len, input int tag);
      bank_t b;
      word_t w;
      b.id  = bank_ctr;
      b.len = len[AW-1:0];
      b.tag = tag[TW-1:0];
      bank_ctr++;
      pending.push_back(b);
      for (int a = 0; a <= len; a++) begin
         w.dat = gen(b.id, a[AW-1:0]);
         w.sop = (a == 0);
         w.eop = (a == len);
         w.tag = b.tag;
         exp_q.push_back(w);
      end
      exp_rel++;
      update_buf();
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge iclk);
      #1;
   endtask

   task automatic wait_drain();
      int i;
      i = 0;
      while ((exp_q.size() != 0 || pending.size() != 0 || obusy) && i < 3000) begin
         step(1);
         i++;
      end
      check("drain_left", exp_q.size() + pending.size(), 0);
      check("release_count", rel_cnt, exp_rel);
   endtask

   // sink and release monitor, sampled mid-cycle
   always @(negedge iclk) begin
      if (ireset && iclkena) begin
         if (oval && ordy) begin : g_word
            word_t w;
            check("word_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               w = exp_q.pop_front();
               check("word_dat", odat, w.dat);
               check("word_sop", osop, w.sop);
               check("word_eop", oeop, w.eop);
               check("word_tag", otag, w.tag);
            end
         end
         if (obuf_rempty) begin
            rel_cnt++;
            check("release_has_bank", pending.size() != 0, 1);
            if (pending.size() != 0) pending.delete(0);
            update_buf();
         end
      end
   end

   initial begin : g_main
      int gap;
      logic found;

      update_buf();
      step(3);
      check("rst_oval", oval, 0);
      check("rst_osop", osop, 0);
      check("rst_oeop", oeop, 0);
      check("rst_odat", odat, 0);
      check("rst_otag", otag, 0);
      check("rst_rempty", obuf_rempty, 0);
      check("rst_raddr", obuf_raddr, 0);
      check("rst_obusy", obusy, 0);
      ireset = 1'b1;
      step(2);

      // single block of 8 words, exact timing
      push_block(7, 5);
      step(1);
      check("t1_busy_start", obusy, 1);
      check("t1_oval_t", oval, 0);
      step(2);
      check("t1_oval_t2", oval, 0);
      step(1);
      check("t1_oval_t3", oval, 1);
      check("t1_sop_t3", osop, 1);
      check("t1_tag_t3", otag, 5);
      check("t1_raddr_t3", obuf_raddr, 3);
      check("t1_dat_t3", odat, exp_q[0].dat);
      step(6);
      check("t1_rempty_t9", obuf_rempty, 0);
      check("t1_busy_t9", obusy, 1);
      step(1);
      check("t1_rempty_t10", obuf_rempty, 1);
      check("t1_busy_t10", obusy, 0);
      step(1);
      check("t1_rempty_t11", obuf_rempty, 0);
      wait_drain();

      // single-word block
      push_block(0, 10);
      step(4);
      check("t2_oval", oval, 1);
      check("t2_sop", osop, 1);
      check("t2_eop", oeop, 1);
      check("t2_rempty", obuf_rempty, 1);
      step(1);
      check("t2_rempty_off", obuf_rempty, 0);
      wait_drain();

      // random backpressure, then strict toggling
      for (int i = 0; i < 200; i++) begin
         if (i % 30 == 0) push_block($urandom_range(0, 12), $urandom_range(0, 15));
         ordy = 1'($urandom_range(0, 1));
         step(1);
      end
      for (int i = 0; i < 60; i++) begin
         if (i % 20 == 0) push_block($urandom_range(0, 12), $urandom_range(0, 15));
         ordy = ~ordy;
         step(1);
      end
      ordy = 1'b1;
      wait_drain();

      // long stall: exactly four words held, address frozen
      push_block(15, 6);
      step(4);
      ordy = 1'b0;
      step(6);
      check("stall_raddr_a", obuf_raddr, 4);
      check("stall_oval_a", oval, 1);
      step(14);
      check("stall_raddr_b", obuf_raddr, 4);
      check("stall_oval_b", oval, 1);
      ordy = 1'b1;
      wait_drain();

      // back-to-back banks, tags 3 then 9
      push_block(5, 3);
      push_block(4, 9);
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         step(1);
         if (obuf_rempty) found = 1'b1;
      end
      check("b2b_rel_seen", found, 1);
      gap = 0;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step(1);
         gap++;
         if (oval && osop) found = 1'b1;
         else check("b2b_otag_hold", otag, 3);
      end
      check("b2b_sop_seen", found, 1);
      check("b2b_gap", gap, 5);
      check("b2b_otag_new", otag, 9);
      wait_drain();

      // clock enable low for 5 cycles mid-block
      push_block(10, 12);
      step(4);
      check("ce_raddr_pre", obuf_raddr, 3);
      iclkena = 1'b0;
      step(5);
      check("ce_raddr_hold", obuf_raddr, 3);
      check("ce_oval_hold", oval, 1);
      check("ce_sop_hold", osop, 1);
      check("ce_dat_hold", odat, exp_q[0].dat);
      check("ce_busy_hold", obusy, 1);
      check("ce_no_pulse", obuf_rempty, 0);
      iclkena = 1'b1;
      wait_drain();

      // reset in the middle of a block
      push_block(20, 7);
      step(6);
      ireset = 1'b0;
      #1;
      check("mrst_oval", oval, 0);
      check("mrst_osop", osop, 0);
      check("mrst_oeop", oeop, 0);
      check("mrst_odat", odat, 0);
      check("mrst_otag", otag, 0);
      check("mrst_rempty", obuf_rempty, 0);
      check("mrst_raddr", obuf_raddr, 0);
      check("mrst_obusy", obusy, 0);
      exp_q.delete();
      exp_rel -= pending.size();
      pending.delete();
      update_buf();
      step(2);
      ireset = 1'b1;
      step(10);
      check("post_rst_oval", oval, 0);
      check("post_rst_busy", obusy, 0);
      push_block(3, 2);
      wait_drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
